// File: rtl/prio_encoder_arb.sv
// ---------------------------------------------------------------------------
// prio_encoder_arb
//
// Registered priority encoder / arbiter for N active-low request lines.
// Falling edges on req_n are latched into pending bits. Unmasked pending
// channels compete in one of two modes: fixed priority, where the highest
// index wins, or round-robin, which searches downward from a rotating
// pointer. The winner is presented on code with valid, and it stays stable
// until the consumer acknowledges it.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   en_n     - active-low enable; high blocks new grants (pending still kept)
//   req_n    - [N] active-low request lines
//   mask     - [N] 1 = channel excluded from selection
//   rr_mode  - 0 = fixed priority, 1 = round-robin
//   ack      - consumer accepts the current grant (ignored when valid=0)
//   valid    - a grant is presented on code
//   code     - [W] binary index of the granted channel
//   pend     - [N] registered pending bits
//   any_pend - OR of pend (registered)
// ---------------------------------------------------------------------------
module prio_encoder_arb #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_n,
  input  logic [N-1:0] req_n,
  input  logic [N-1:0] mask,
  input  logic         rr_mode,
  input  logic         ack,
  output logic         valid,
  output logic [W-1:0] code,
  output logic [N-1:0] pend,
  output logic         any_pend
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   req_q, req_d;
  logic [N-1:0]   pend_q, pend_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [W-1:0]   code_q, code_d;
  logic           valid_q, valid_d;
  logic           any_pend_q, any_pend_d;

  logic [N-1:0]   eligible;
  logic [N-1:0]   fall_set;
  logic [N-1:0]   grant_clr;
  logic           accept;
  logic [W-1:0]   search_start;
  logic [W-1:0]   winner;
  logic           winner_found;
  int             idx;
  logic [W-1:0]   idx_w;

  // A grant is only consumed while it is actually being presented.
  assign accept   = (state_q == GRANT) && ack;
  assign eligible = pend_q & ~mask;

  // Winner search. Fixed priority is just a downward search from N-1, so
  // both modes share one loop and differ only in the starting index.
  always_comb begin
    search_start = rr_mode ? ptr_q : W'(N - 1);
    winner       = '0;
    winner_found = 1'b0;
    idx          = 0;
    idx_w        = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(search_start) - k;
      if (idx < 0) begin
        idx = idx + N;
      end
      idx_w = W'(idx);
      if (!winner_found && eligible[idx_w]) begin
        winner_found = 1'b1;
        winner       = idx_w;
      end
    end
  end

  // Pending bits: a falling edge sets, an accepted grant clears. The set
  // term is OR-ed in last so a fresh edge wins over a simultaneous clear.
  always_comb begin
    req_d      = req_n;
    fall_set   = req_q & ~req_n;
    grant_clr  = accept ? ({{(N-1){1'b0}}, 1'b1} << code_q) : '0;
    pend_d     = (pend_q & ~grant_clr) | fall_set;
    any_pend_d = |pend_d;
  end

  // Grant FSM. The pointer moves on every accepted grant regardless of mode,
  // so switching to round-robin later continues from the last serviced slot.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (!en_n && winner_found) begin
          state_d = GRANT;
          valid_d = 1'b1;
          code_d  = winner;
        end
      end
      GRANT: begin
        // mask / en_n / rr_mode changes deliberately have no effect here.
        if (ack) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ptr_d   = (code_q == '0) ? W'(N - 1) : (code_q - W'(1));
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= '1;
      pend_q     <= '0;
      ptr_q      <= W'(N - 1);
      code_q     <= '0;
      valid_q    <= 1'b0;
      any_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      pend_q     <= pend_d;
      ptr_q      <= ptr_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      any_pend_q <= any_pend_d;
    end
  end

  assign valid    = valid_q;
  assign code     = code_q;
  assign pend     = pend_q;
  assign any_pend = any_pend_q;

endmodule
